// File: rtl/mult32_seq_pkg.sv
// Shared definitions for the iterative shift-add multiplier: operand width,
// FSM state codes and the two's-complement helpers used on operands and results.
package mult32_seq_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic logic [WIDTH-1:0] twoscomp32(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] twoscomp64(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

endpackage

// File: rtl/mult32_seq_if.sv
// Request/response bundle between the control unit (master) and the multiplier (slave).
interface mult32_seq_if;
  import mult32_seq_pkg::*;

  logic             START;
  logic             SIGNED;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output START, SIGNED, A, B,
    input  BUSY, DONE, HI, LO
  );

  modport slave (
    input  START, SIGNED, A, B,
    output BUSY, DONE, HI, LO
  );

endinterface

// File: rtl/mult32_step.sv
// One shift-add step: conditionally add the multiplicand into the accumulator,
// then shift {carry, acc, mplier} right by one bit.
module mult32_step
  import mult32_seq_pkg::*;
(
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mplier_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mplier_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum      = {1'b0, acc_i} + (mplier_i[0] ? {1'b0, mcand_i} : '0);
    acc_o    = sum[WIDTH:1];
    mplier_o = {sum[0], mplier_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/mult32_seq.sv
// Iterative 32x32 -> 64 multiplier (signed or unsigned): magnitudes are multiplied
// over 32 shift-add steps, then the sign is applied in a single fix-up cycle.
module mult32_seq
  import mult32_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  mult32_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_acc, step_mplier;

  mult32_step u_step (
    .acc_i    (acc_q),
    .mplier_i (mplier_q),
    .mcand_i  (mcand_q),
    .acc_o    (step_acc),
    .mplier_o (step_mplier)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.START) state_d = S_RUN;
      S_RUN:   if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.BUSY = (state_q != S_IDLE);
    bus.DONE = done_q;
    bus.HI   = hi_q;
    bus.LO   = lo_q;
  end

  // Datapath next-state; the FSM state register above selects which update applies.
  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = (state_q == S_FIX);
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          mcand_d  = (bus.SIGNED & bus.A[WIDTH-1]) ? twoscomp32(bus.A) : bus.A;
          mplier_d = (bus.SIGNED & bus.B[WIDTH-1]) ? twoscomp32(bus.B) : bus.B;
          neg_d    = bus.SIGNED & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        acc_d    = step_acc;
        mplier_d = step_mplier;
        cnt_d    = cnt_q + CNT_W'(1);
      end
      S_FIX: begin
        {hi_d, lo_d} = neg_q ? twoscomp64({acc_q, mplier_q}) : {acc_q, mplier_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_mult32_seq.sv
// Scoreboard bench for mult32_seq: stimulus pushes expected products, a monitor
// pops and checks them (value and latency) whenever DONE is seen.
module tb_mult32_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult32_seq_if bus ();

  mult32_seq dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] prod;
    int unsigned acc_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc   = 0;
  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [63:0] last_prod = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    if (s) begin
      pa = longint'(signed'(a));
      pb = longint'(signed'(b));
      return 64'(pa * pb);
    end
    return 64'({32'd0, a}) * 64'({32'd0, b});
  endfunction

  // Monitor: every DONE must match the oldest outstanding request.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.DONE === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(bus.DONE), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("product", {bus.HI, bus.LO}, mon_e.prod);
        check("latency", 64'(cyc - mon_e.acc_cyc), 64'd33);
        check("busy_in_done", 64'(bus.BUSY), 64'd0);
        last_prod = mon_e.prod;
      end
    end
  end

  // Called at a negedge with the DUT idle (or in its DONE cycle).
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] req);
    exp_t e;
    bus.START  = 1'b1;
    bus.SIGNED = s;
    bus.A      = a;
    bus.B      = b;
    e.prod     = req;
    e.acc_cyc  = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
    bus.START  = 1'b0;
    bus.SIGNED = 1'($urandom);
    bus.A      = $urandom;
    bus.B      = $urandom;
  endtask

  task automatic issue_m(input logic s, input logic [31:0] a, input logic [31:0] b);
    issue(s, a, b, ref_mul(s, a, b));
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((sb_q.size() != 0 || bus.BUSY === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  logic [31:0] corners [6] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                               32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_FFFF};

  initial begin
    int unsigned n;
    logic [31:0] ra, rb;
    rst        = 1'b1;
    bus.START  = 1'b0;
    bus.SIGNED = 1'b0;
    bus.A      = '0;
    bus.B      = '0;
    #1;
    check("reset_busy", 64'(bus.BUSY), 64'd0);
    check("reset_done", 64'(bus.DONE), 64'd0);
    check("reset_hilo", {bus.HI, bus.LO}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Unsigned max
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_idle();

    // Reset while running: discarded, no DONE, outputs cleared
    issue_m(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrun_busy", 64'(bus.BUSY), 64'd0);
    check("midrun_done", 64'(bus.DONE), 64'd0);
    check("midrun_hilo", {bus.HI, bus.LO}, 64'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_reset_hilo", {bus.HI, bus.LO}, 64'd0);
    issue_m(1'b0, 32'd1000, 32'd3000);
    wait_idle();

    // Signed directed cases
    issue(1'b1, 32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB);
    wait_idle();
    issue(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    wait_idle();
    issue(1'b1, 32'h8000_0000, 32'd1,        64'hFFFF_FFFF_8000_0000);
    wait_idle();
    issue(1'b1, 32'd0,         32'hFFFF_FFFB, 64'd0);
    wait_idle();

    // START while busy is ignored
    issue(1'b0, 32'd6, 32'd7, 64'd42);
    repeat (4) @(negedge clk);
    bus.START = 1'b1;
    bus.A     = 32'd2;
    bus.B     = 32'd2;
    @(negedge clk);
    bus.START = 1'b0;
    wait_idle();

    // Back-to-back: START in the DONE cycle is accepted, old result held meanwhile
    issue(1'b1, 32'd9, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFEE);
    n = 0;
    while (bus.DONE !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done", 64'(bus.DONE), 64'd1);
    issue(1'b0, 32'd2, 32'd2, 64'd4);
    repeat (5) @(negedge clk);
    check("hold_during_run", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFEE);
    wait_idle();

    // Randomized, with corner operands mixed in
    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      issue_m(1'($urandom), ra, rb);
      if ($urandom_range(0, 1) == 1) wait_idle();
      else begin
        n = 0;
        while (bus.DONE !== 1'b1 && n < 100) begin
          @(negedge clk);
          n++;
        end
      end
    end
    wait_idle();

    repeat (6) @(negedge clk);
    check("final_hold", {bus.HI, bus.LO}, last_prod);
    check("final_idle_done", 64'(bus.DONE), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
